// File: rtl/demux18_deser.sv
// Serial-to-parallel frame assembler: steers each incoming bit of `c` into a frame
// position (external select or internal scan counter) and emits the byte once all positions are written.
module demux18_deser #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c,
    input  logic [SW-1:0] s,
    input  logic          wr_en,
    input  logic          mode,
    output logic [N-1:0]  a,
    output logic          a_valid,
    output logic [N-1:0]  wmask,
    output logic          dup,
    output logic [SW-1:0] cnt
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic          a_valid_q, a_valid_d;
    logic [N-1:0]  wmask_q, wmask_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic          dup_q, dup_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;

    logic          mode_chg;
    logic [N-1:0]  base_mask, base_shadow, onehot, new_mask, new_shadow;
    logic [SW-1:0] base_cnt, pos;

    always_comb begin
        // A mode change discards the partial frame before this cycle's write lands.
        mode_chg    = (mode != mode_q);
        base_mask   = (state_q == IDLE || mode_chg) ? '0 : wmask_q;
        base_shadow = mode_chg ? '0 : shadow_q;
        base_cnt    = mode_chg ? '0 : cnt_q;
        pos         = mode ? base_cnt : s;
        onehot      = N'(1) << pos;
        new_mask    = base_mask | onehot;
        new_shadow  = base_shadow;
        new_shadow[pos] = c;

        a_d       = a_q;
        a_valid_d = 1'b0;
        dup_d     = 1'b0;
        wmask_d   = base_mask;
        shadow_d  = base_shadow;
        cnt_d     = base_cnt;
        mode_d    = mode;

        if (wr_en) begin
            dup_d = ((base_mask & onehot) != '0);
            cnt_d = mode ? base_cnt + SW'(1) : base_cnt;
            if (&new_mask) begin
                a_d       = new_shadow;
                a_valid_d = 1'b1;
                wmask_d   = '0;
                shadow_d  = '0;
            end else begin
                wmask_d  = new_mask;
                shadow_d = new_shadow;
            end
        end

        state_d = (wmask_d != '0) ? FILL : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            wmask_q   <= '0;
            shadow_q  <= '0;
            dup_q     <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            wmask_q   <= wmask_d;
            shadow_q  <= shadow_d;
            dup_q     <= dup_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign wmask   = wmask_q;
    assign dup     = dup_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_demux18_deser.sv
// Bench for demux18_deser: a frame-level reference model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_demux18_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       c;
    logic [2:0] s;
    logic       wr_en;
    logic       mode;
    logic [7:0] a;
    logic       a_valid;
    logic [7:0] wmask;
    logic       dup;
    logic [2:0] cnt;

    int errors = 0;
    int checks = 0;

    demux18_deser #(.N(8), .SW(3)) dut (
        .clk(clk), .rst(rst), .c(c), .s(s), .wr_en(wr_en), .mode(mode),
        .a(a), .a_valid(a_valid), .wmask(wmask), .dup(dup), .cnt(cnt)
    );

    always #5 clk = ~clk;

    // Reference model: frame as an array of bits plus a "written" flag per slot.
    int         bits_m [8];
    int         seen_m [8];
    int         cnt_m;
    int         mode_prev_m;
    logic [7:0] a_m;
    logic       av_m;
    logic       dup_m;
    logic [7:0] mask_m;
    bit         model_ok = 1'b0;

    function automatic logic [7:0] mask_of();
        int m = 0;
        for (int i = 0; i < 8; i++) m += seen_m[i] * (1 << i);
        return 8'(m);
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            bits_m[i] = 0;
            seen_m[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            clear_frame();
            cnt_m = 0; mode_prev_m = 0; a_m = 8'h00; av_m = 1'b0; dup_m = 1'b0;
            model_ok = 1'b1;
        end else begin
            int pos, total, val;
            av_m = 1'b0;
            dup_m = 1'b0;
            if (int'(mode) != mode_prev_m) begin
                clear_frame();
                cnt_m = 0;
            end
            if (wr_en) begin
                pos = mode ? cnt_m : int'(s);
                if (seen_m[pos] != 0) dup_m = 1'b1;
                bits_m[pos] = int'(c);
                seen_m[pos] = 1;
                if (mode) cnt_m = (cnt_m + 1) % 8;
                total = 0;
                val = 0;
                for (int i = 0; i < 8; i++) begin
                    total += seen_m[i];
                    val += bits_m[i] * (1 << i);
                end
                if (total == 8) begin
                    a_m = 8'(val);
                    av_m = 1'b1;
                    clear_frame();
                end
            end
            mode_prev_m = int'(mode);
        end
        mask_m = mask_of();
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("a", a, a_m);
            chk("a_valid", {7'd0, a_valid}, {7'd0, av_m});
            chk("wmask", wmask, mask_m);
            chk("dup", {7'd0, dup}, {7'd0, dup_m});
            chk("cnt", {5'd0, cnt}, 8'(cnt_m));
        end
    end

    // Apply one cycle of inputs, return just after the following falling edge.
    task automatic drive(input logic r, input logic w, input logic m, input logic [2:0] sel, input logic d);
        rst = r; wr_en = w; mode = m; s = sel; c = d;
        @(negedge clk);
    endtask

    task automatic scan_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 3'd0, v[i]);
    endtask

    logic [2:0] sel_t [8];
    logic       dat_t [8];

    initial begin
        rst = 1'b1; wr_en = 1'b1; mode = 1'b0; s = 3'd0; c = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("idle_a", a, 8'h00);
        chk("idle_cnt", {5'd0, cnt}, 8'h00);

        // Scan mode, two back-to-back frames.
        scan_byte(8'hA5);
        chk("scan1_a", a, 8'hA5);
        chk("scan1_valid", {7'd0, a_valid}, 8'h01);
        chk("scan1_wmask", wmask, 8'h00);
        scan_byte(8'h3C);
        chk("scan2_a", a, 8'h3C);
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        chk("scan2_drop", {7'd0, a_valid}, 8'h00);

        // Addressed, out of order: bits 7,0,3,5 set -> 8'hA9.
        sel_t = '{3'd7, 3'd0, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
        dat_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, sel_t[i], dat_t[i]);
            if (i == 0) chk("addr_wmask1", wmask, 8'h80);
        end
        chk("addr_a", a, 8'hA9);
        chk("addr_valid", {7'd0, a_valid}, 8'h01);

        // Duplicate write to slot 2, last write (0) wins.
        drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        chk("dup_pulse", {7'd0, dup}, 8'h01);
        chk("dup_wmask", wmask, 8'h04);
        for (int i = 0; i < 8; i++)
            if (i != 2) drive(1'b0, 1'b1, 1'b0, 3'(i), 1'b1);
        chk("dup_a", a, 8'hFB);

        // Mode change mid-frame discards the scan bits.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
        chk("mchg_wmask", wmask, 8'h40);
        chk("mchg_cnt", {5'd0, cnt}, 8'h00);
        chk("mchg_valid", {7'd0, a_valid}, 8'h00);
        for (int i = 0; i < 8; i++)
            if (i != 6) drive(1'b0, 1'b1, 1'b0, 3'(i), 1'b0);
        chk("mchg_a", a, 8'h40);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        chk("rst_wmask", wmask, 8'h00);
        chk("rst_cnt", {5'd0, cnt}, 8'h00);
        chk("rst_a", a, 8'h00);
        scan_byte(8'h81);
        chk("post_rst_a", a, 8'h81);
        chk("post_rst_valid", {7'd0, a_valid}, 8'h01);
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
